// File: rtl/placar_pkg.sv
// Shared types and constants for the multi-player scoreboard.
package placar_pkg;

  // Game FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_OVER    = 2'd2
  } state_t;

  // Width of the winner index output (up to 8 players)
  localparam int PLAYER_IDX_W = 3;

endpackage

// File: rtl/edge_rise_n.sv
// W-wide rising-edge detector. A level held high yields a single pulse;
// a high level at reset release counts as an edge because the history is 0.
module edge_rise_n #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_pulse
);

  logic [W-1:0] r_d;

  // History register tracks the input every cycle, in every game state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_d <= '0;
    else          r_d <= i_d;
  end

  assign o_pulse = i_d & ~r_d;

endmodule

// File: rtl/placar_multi.sv
// N-player point scoreboard: saturating scores, first-to-N or win-by-two,
// draw detection, LED thermometers with a blinking winner segment.
module placar_multi
  import placar_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int WIN_POINTS  = 7,
  parameter int MAX_POINTS  = 15,
  parameter int BLINK_DIV   = 25000000,
  // Derived from MAX_POINTS; leave at its default
  parameter int PTS_W       = $clog2(MAX_POINTS + 1)
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [NUM_PLAYERS-1:0]            vic,
  input  logic                              deuce_mode,
  input  logic                              new_game,
  output logic [NUM_PLAYERS*PTS_W-1:0]      pontos,
  output logic [NUM_PLAYERS*WIN_POINTS-1:0] LED,
  output logic                              game_over,
  output logic [PLAYER_IDX_W-1:0]           winner,
  output logic                              draw
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [PTS_W-1:0] SAT_MAX    = PTS_W'(MAX_POINTS);
  localparam logic [PTS_W-1:0] WIN_TH     = PTS_W'(WIN_POINTS);

  logic [NUM_PLAYERS-1:0]            w_pulse;
  logic [NUM_PLAYERS-1:0][PTS_W-1:0] r_score;
  logic [NUM_PLAYERS-1:0][PTS_W-1:0] w_score_nxt;
  logic [NUM_PLAYERS-1:0]            w_win;
  logic [NUM_PLAYERS-1:0]            r_win_mask;
  logic [PLAYER_IDX_W-1:0]           w_win_idx;
  logic                              w_scoring;
  logic                              w_decide;
  logic [BW-1:0]                     r_blink_cnt;
  logic                              r_blink_vis;
  logic                              r_game_over;
  logic [PLAYER_IDX_W-1:0]           r_winner;
  logic                              r_draw;
  state_t                            r_state, w_state_nxt;

  edge_rise_n #(.W(NUM_PLAYERS)) u_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .i_d     (vic),
    .o_pulse (w_pulse)
  );

  // Scores only move outside OVER; once frozen the win check sees no change
  assign w_scoring = (r_state != ST_OVER);

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
    logic [PTS_W-1:0] w_max_o;
    logic [PTS_W:0]   w_ext_me, w_ext_lim;

    assign w_score_nxt[g] = (w_scoring && w_pulse[g] && (r_score[g] != SAT_MAX))
                          ? r_score[g] + PTS_W'(1) : r_score[g];

    // Highest next-state score among the other players
    always_comb begin
      w_max_o = '0;
      for (int j = 0; j < NUM_PLAYERS; j++)
        if (j != g && w_score_nxt[j] > w_max_o) w_max_o = w_score_nxt[j];
    end

    // One extra bit so "+2" cannot wrap near saturation
    assign w_ext_me  = {1'b0, w_score_nxt[g]};
    assign w_ext_lim = {1'b0, w_max_o} + (PTS_W+1)'(2);
    assign w_win[g]  = (w_score_nxt[g] >= WIN_TH) && (!deuce_mode || (w_ext_me >= w_ext_lim));

    // Thermometer is score > k, which saturates at WIN_POINTS by construction
    for (genvar k = 0; k < WIN_POINTS; k++) begin : g_seg
      assign LED[g*WIN_POINTS + k] = (r_score[g] > PTS_W'(k)) && !(r_win_mask[g] && !r_blink_vis);
    end

    assign pontos[g*PTS_W +: PTS_W] = r_score[g];
  end

  // Lowest winning index wins ties
  always_comb begin
    w_win_idx = '0;
    for (int j = NUM_PLAYERS - 1; j >= 0; j--)
      if (w_win[j]) w_win_idx = PLAYER_IDX_W'(j);
  end

  assign w_decide = w_scoring && (|w_win) && !new_game;

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state: first pulse starts play, any winner ends it, new_game overrides
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (|w_pulse) w_state_nxt = ST_PLAYING;
      ST_PLAYING: w_state_nxt = ST_PLAYING;
      ST_OVER:    w_state_nxt = ST_OVER;
      default:    w_state_nxt = ST_IDLE;
    endcase
    if (w_decide) w_state_nxt = ST_OVER;
    if (new_game) w_state_nxt = ST_IDLE;
  end

  // Scores, result latch and winner blink timer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_score     <= '0;
      r_game_over <= 1'b0;
      r_winner    <= '0;
      r_draw      <= 1'b0;
      r_win_mask  <= '0;
      r_blink_cnt <= '0;
      r_blink_vis <= 1'b1;
    end else if (new_game) begin
      r_score     <= '0;
      r_game_over <= 1'b0;
      r_winner    <= '0;
      r_draw      <= 1'b0;
      r_win_mask  <= '0;
      r_blink_cnt <= '0;
      r_blink_vis <= 1'b1;
    end else begin
      r_score <= w_score_nxt;
      if (w_decide) begin
        r_game_over <= 1'b1;
        r_winner    <= w_win_idx;
        r_draw      <= |(w_win & (w_win - 1'b1));
        r_win_mask  <= w_win;
        r_blink_cnt <= '0;
        r_blink_vis <= 1'b1;
      end else if (r_game_over) begin
        if (r_blink_cnt == BLINK_LAST) begin
          r_blink_cnt <= '0;
          r_blink_vis <= ~r_blink_vis;
        end else begin
          r_blink_cnt <= r_blink_cnt + BW'(1);
        end
      end
    end
  end

  assign game_over = r_game_over;
  assign winner    = r_winner;
  assign draw      = r_draw;

endmodule

// File: tb/tb_placar_multi.sv
// Directed bench for placar_multi: 2 players, first-to-7, fast blink.
module tb_placar_multi;

  localparam int NP = 2;
  localparam int WP = 7;
  localparam int PW = 4;

  logic          clock, reset_n, deuce_mode, new_game;
  logic [NP-1:0] vic;
  logic [NP*PW-1:0] pontos;
  logic [NP*WP-1:0] LED;
  logic          game_over, draw;
  logic [2:0]    winner;

  int n_chk  = 0;
  int n_fail = 0;

  placar_multi #(
    .NUM_PLAYERS(NP), .WIN_POINTS(WP), .MAX_POINTS(15), .BLINK_DIV(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .vic(vic), .deuce_mode(deuce_mode),
    .new_game(new_game), .pontos(pontos), .LED(LED), .game_over(game_over),
    .winner(winner), .draw(draw)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic restart();
    new_game = 1'b1; tick(); new_game = 1'b0; tick();
  endtask

  initial begin
    reset_n = 1'b0; vic = '0; deuce_mode = 1'b0; new_game = 1'b0;
    #12;
    chk("rst_pontos", 32'(pontos), 0);
    chk("rst_led", 32'(LED), 0);
    chk("rst_go", 32'({game_over, draw, winner}), 0);
    #1 reset_n = 1'b1;
    tick();

    // Player 0 scores seven times
    for (int k = 1; k <= 7; k++) begin
      vic[0] = 1'b1; tick();
      chk($sformatf("p0_score%0d", k), 32'(pontos[3:0]), 32'(k));
      chk($sformatf("p0_led%0d", k), 32'(LED[6:0]), (32'd1 << k) - 1);
      chk($sformatf("p0_go%0d", k), 32'(game_over), (k == 7) ? 1 : 0);
      vic[0] = 1'b0; tick();
    end
    chk("p0_winner", 32'(winner), 0);
    chk("p0_draw", 32'(draw), 0);

    // new_game with a simultaneous rising edge on player 0
    new_game = 1'b1; vic[0] = 1'b1; tick();
    new_game = 1'b0;
    chk("ng_pontos", 32'(pontos), 0);
    chk("ng_led", 32'(LED), 0);
    chk("ng_go", 32'({game_over, draw, winner}), 0);
    tick();
    chk("ng_held", 32'(pontos), 0);
    vic[0] = 1'b0; tick();

    // Held level on player 1 scores once
    vic[1] = 1'b1; tick();
    chk("hold_first", 32'(pontos[7:4]), 1);
    chk("hold_led", 32'(LED[7]), 1);
    repeat (19) tick();
    chk("hold_20", 32'(pontos), 32'h10);
    vic[1] = 1'b0; tick();
    vic[1] = 1'b1; tick();
    chk("hold_again", 32'(pontos[7:4]), 2);
    vic[1] = 1'b0;
    restart();

    // Simultaneous final point -> draw, both segments blink
    for (int k = 0; k < 6; k++) begin
      vic = 2'b11; tick(); vic = 2'b00; tick();
    end
    chk("draw_66", 32'(pontos), 32'h66);
    chk("draw_66_go", 32'(game_over), 0);
    vic = 2'b11; tick(); vic = 2'b00;
    chk("draw_pontos", 32'(pontos), 32'h77);
    chk("draw_flags", 32'({game_over, draw, winner}), 32'b1_1_000);
    chk("draw_led_on0", 32'(LED), 32'h3FFF);
    repeat (3) tick();
    chk("draw_led_on3", 32'(LED), 32'h3FFF);
    tick();
    chk("draw_led_off4", 32'(LED), 0);
    repeat (3) tick();
    chk("draw_led_off7", 32'(LED), 0);
    tick();
    chk("draw_led_on8", 32'(LED), 32'h3FFF);
    vic = 2'b01; tick(); vic = 2'b00;
    chk("over_frozen", 32'(pontos), 32'h77);
    restart();

    // Win-by-two
    deuce_mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      vic = 2'b11; tick(); vic = 2'b00; tick();
    end
    vic = 2'b01; tick(); vic = 2'b00; tick();
    chk("deuce_76", 32'({game_over, pontos}), 32'h067);
    vic = 2'b10; tick(); vic = 2'b00; tick();
    chk("deuce_77", 32'({game_over, pontos}), 32'h077);
    vic = 2'b01; tick(); vic = 2'b00; tick();
    chk("deuce_87", 32'({game_over, pontos}), 32'h078);
    vic = 2'b01; tick(); vic = 2'b00;
    chk("deuce_97", 32'({game_over, pontos}), 32'h179);
    chk("deuce_win", 32'({draw, winner}), 0);
    chk("deuce_led", 32'(LED), 32'h3FFF);
    deuce_mode = 1'b0;
    restart();

    // Asynchronous reset mid-game, then vic[1] high at release
    vic = 2'b01; tick(); vic = 2'b00; tick();
    chk("ar_pre", 32'(pontos), 1);
    #2 reset_n = 1'b0; vic[1] = 1'b1;
    #1;
    chk("ar_clear", 32'({pontos, LED, game_over}), 0);
    #1 reset_n = 1'b1;
    tick();
    chk("ar_p1", 32'(pontos), 32'h10);
    vic = '0; tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/placar_multi.md
Name: placar_multi

Overview:
- Parametrised scoreboard for an N-player point game; successor to the fixed two-player, first-to-7 scorer.
- Edge-detects each player's point input, keeps a saturating score per player and decides the winner.
- Supports first-to-WIN_POINTS and win-by-two (deuce) modes and a draw on simultaneous final points.
- Drives a per-player LED thermometer that blinks the winner's segment after game over, and supports restart without reset.

Parameters:
- NUM_PLAYERS, 2, number of players (2..8).
- WIN_POINTS, 7, points needed to win (1..15).
- MAX_POINTS, 15, score saturation ceiling; must be >= WIN_POINTS+1.
- BLINK_DIV, 25000000, clock cycles per half-period of the winner blink.
- PTS_W, $clog2(MAX_POINTS+1), score width (derived; do not override).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- vic  in  NUM_PLAYERS  level "player i scored" inputs; bit i = player i.
- deuce_mode  in  1  0 = first-to-WIN_POINTS, 1 = win-by-two; sampled only in IDLE/PLAYING.
- new_game  in  1  1-cycle request to clear scores and restart.
- pontos  out  NUM_PLAYERS*PTS_W  packed scores; player i at [i*PTS_W +: PTS_W].
- LED  out  NUM_PLAYERS*WIN_POINTS  thermometer per player; segment i at [i*WIN_POINTS +: WIN_POINTS]; bit k = score > k.
- game_over  out  1  high from decision cycle until restart.
- winner  out  3  index of winning player; lowest index on a draw.
- draw  out  1  more than one player won in the same cycle.

Behaviour:
- Reset (reset_n low, asynchronous): all scores, edge registers, LED, game_over, winner, draw = 0; blink counter = 0; FSM = IDLE.
- Edge detect: vic_r registered every cycle; pulse[i] = vic[i] & ~vic_r[i]. A level held high scores once. vic high at reset release counts as a rising edge (vic_r = 0).
- FSM states:
  - IDLE: entered after reset/restart. Go to PLAYING on any pulse; that pulse is scored the same cycle.
  - PLAYING: each cycle, every player with a pulse gets +1, saturating at MAX_POINTS. All simultaneous pulses are counted.
  - OVER: game_over = 1. Pulses are ignored, but vic_r still tracks vic. Scores are frozen.
- Win check runs on the next-state scores in the same clock edge, so game_over rises on the edge that registers the winning point (latency 1 from the pulse).
  - deuce_mode = 0: player wins if score >= WIN_POINTS.
  - deuce_mode = 1: player wins if score >= WIN_POINTS and score >= (max of the other players' scores) + 2.
- Multiple winners in one cycle: draw = 1; winner = lowest winning index. State goes to OVER.
- Saturation in deuce: if the leader is at MAX_POINTS and the lead is still < 2, score stays at MAX_POINTS. The game can then only end via new_game (documented limitation).
- LED:
  - PLAYING/IDLE: segment i = thermometer of min(score_i, WIN_POINTS).
  - OVER: the winner's segment (all winners' segments on a draw) toggles between its thermometer and all-zero every BLINK_DIV cycles, starting visible. Other segments are static.
- new_game: from any state, on the next edge clear scores, LED, game_over, winner, draw and the blink counter; FSM = IDLE. A pulse in the same cycle as new_game is discarded. new_game has priority over scoring.
- Scores use unsigned PTS_W arithmetic. The comparison "+2" is done at PTS_W+1 bits to avoid wrap.

Decomposition:
- Package placar_pkg: FSM state enum (IDLE, PLAYING, OVER) and the constant PLAYER_IDX_W = 3.
- One sub-module, edge_rise_n: a NUM_PLAYERS-wide rising-edge detector with async active-low reset.
- Win logic, blink counter and LED mapping stay in placar_multi.

Test Plan:
- Default params, vic[0] pulsed 7 times (idle gaps between): pontos[0] steps 1..7. LED[6:0] fills bit by bit. game_over = 1 on the 7th edge, winner = 0, draw = 0.
- vic[1] held high 20 cycles: exactly one point, LED[7] = 1, no further change until vic[1] drops and rises again.
- Both players at 6, vic = 2'b11 in one cycle: both scores go to 7, game_over = 1, draw = 1, winner = 0. Both segments blink with period 2*BLINK_DIV (test with BLINK_DIV = 4).
- deuce_mode = 1, scores 6-6, P0 scores (7-6): no game_over. P1 scores (7-7), then P0 twice (9-7): game_over = 1, winner = 0. LED segment 0 stays all-ones (capped at WIN_POINTS).
- Game over, then new_game for 1 cycle with vic[0] rising simultaneously: all outputs return to 0, state IDLE, and that point is not counted.
- reset_n asserted mid-game asynchronously (between clock edges): outputs clear immediately. After release with vic[1] already high, one point is credited to player 1 on the first edge.
